// File: rtl/mem_arb_pkg.sv
// ============================================================
// mem_arb_pkg : shared types for the instruction/data memory arbiter
// Rev 1.0
// ============================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================
// mem_arbiter_if : fetch, data and shared-memory ports of mem_arbiter
// Rev 1.0
// ============================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) ();

  logic                      i_req;
  logic [ADDRESS_WIDTH-1:0]  i_addr;
  logic                      i_gnt;
  logic                      i_rvalid;
  logic [DATA_WIDTH-1:0]     i_rdata;

  logic                      d_req;
  logic                      d_we;
  logic [DATA_WIDTH/8-1:0]   d_be;
  logic [ADDRESS_WIDTH-1:0]  d_addr;
  logic [DATA_WIDTH-1:0]     d_wdata;
  logic                      d_gnt;
  logic                      d_rvalid;
  logic [DATA_WIDTH-1:0]     d_rdata;

  logic                      m_req;
  logic                      m_we;
  logic [DATA_WIDTH/8-1:0]   m_be;
  logic [ADDRESS_WIDTH-1:0]  m_addr;
  logic [DATA_WIDTH-1:0]     m_wdata;
  logic                      m_rvalid;
  logic [DATA_WIDTH-1:0]     m_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_be, m_addr, m_wdata
  );

  // Requesters and memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_be, m_addr, m_wdata
  );

endinterface

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================
// arb_starve_ctr : saturating count of data grants that bypassed a fetch
// Rev 1.0
// ============================================================
`default_nettype none

module arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int             CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================
// mem_arbiter : data-priority arbiter with fetch anti-starvation,
//               one outstanding transaction to a shared memory
// Rev 1.0
// ============================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_WIDTH / 8;

  arb_state_e state_q;
  arb_state_e state_d;
  arb_owner_e owner_q;
  arb_owner_e owner_d;

  logic at_limit;
  logic can_grant;
  logic resp;
  logic gnt_i;
  logic gnt_d;

  logic [ADDRESS_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0]    wdata_mux;
  logic [BE_W-1:0]          be_mux;
  logic                     we_mux;

  // rst_n gating keeps grants low while reset is held, without needing a clock
  assign resp      = rst_n && (state_q == WAIT) && bus.m_rvalid;
  assign can_grant = rst_n && ((state_q == IDLE) || resp);
  assign gnt_d     = can_grant && bus.d_req && !(at_limit && bus.i_req);
  assign gnt_i     = can_grant && bus.i_req && !gnt_d;

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (gnt_d && bus.i_req),
    .clr      (gnt_i || (gnt_d && !bus.i_req)),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (gnt_i || gnt_d) begin
      state_d = WAIT;
      owner_d = gnt_d ? OWN_D : OWN_I;
    end else if (resp) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    we_mux    = 1'b0;
    be_mux    = '0;
    addr_mux  = '0;
    wdata_mux = '0;
    if (gnt_d) begin
      we_mux    = bus.d_we;
      be_mux    = bus.d_be;
      addr_mux  = bus.d_addr;
      wdata_mux = bus.d_wdata;
    end else if (gnt_i) begin
      be_mux    = '1;
      addr_mux  = bus.i_addr;
    end

    bus.i_gnt    = gnt_i;
    bus.d_gnt    = gnt_d;
    bus.m_req    = gnt_i || gnt_d;
    bus.m_we     = we_mux;
    bus.m_be     = be_mux;
    bus.m_addr   = addr_mux;
    bus.m_wdata  = wdata_mux;

    bus.i_rvalid = resp && (owner_q == OWN_I);
    bus.d_rvalid = resp && (owner_q == OWN_D);
    bus.i_rdata  = (resp && (owner_q == OWN_I)) ? bus.m_rdata : '0;
    bus.d_rdata  = (resp && (owner_q == OWN_D)) ? bus.m_rdata : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================
// tb_mem_arbiter : directed scenarios plus randomized traffic against a
//                  transaction-level model of the arbiter
// Rev 1.0
// ============================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) arb_bus ();

  mem_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (arb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    arb_bus.i_req    = 1'b0;
    arb_bus.i_addr   = '0;
    arb_bus.d_req    = 1'b0;
    arb_bus.d_we     = 1'b0;
    arb_bus.d_be     = '0;
    arb_bus.d_addr   = '0;
    arb_bus.d_wdata  = '0;
    arb_bus.m_rvalid = 1'b0;
    arb_bus.m_rdata  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    arb_bus.i_req    = 1'b1;
    arb_bus.d_req    = 1'b1;
    arb_bus.m_rvalid = 1'b1;
    #3;
    n_checks++; if (arb_bus.i_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_i_gnt got=%b exp=0", arb_bus.i_gnt); end
    n_checks++; if (arb_bus.d_gnt !== 1'b0)    begin n_fail++; $display("FAIL rst_d_gnt got=%b exp=0", arb_bus.d_gnt); end
    n_checks++; if (arb_bus.m_req !== 1'b0)    begin n_fail++; $display("FAIL rst_m_req got=%b exp=0", arb_bus.m_req); end
    n_checks++; if (arb_bus.i_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_i_rvalid got=%b exp=0", arb_bus.i_rvalid); end
    n_checks++; if (arb_bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_rvalid got=%b exp=0", arb_bus.d_rvalid); end
    drive_idle();
  endtask

  task automatic test_single_fetch();
    next_cycle();
    rst_n = 1'b1;
    arb_bus.i_req  = 1'b1;
    arb_bus.i_addr = 16'h0010;
    @(negedge clk);
    n_checks++; if (arb_bus.i_gnt !== 1'b1)        begin n_fail++; $display("FAIL fetch_i_gnt got=%b exp=1", arb_bus.i_gnt); end
    n_checks++; if (arb_bus.d_gnt !== 1'b0)        begin n_fail++; $display("FAIL fetch_d_gnt got=%b exp=0", arb_bus.d_gnt); end
    n_checks++; if (arb_bus.m_req !== 1'b1)        begin n_fail++; $display("FAIL fetch_m_req got=%b exp=1", arb_bus.m_req); end
    n_checks++; if (arb_bus.m_addr !== 16'h0010)   begin n_fail++; $display("FAIL fetch_m_addr got=%h exp=0010", arb_bus.m_addr); end
    n_checks++; if (arb_bus.m_we !== 1'b0)         begin n_fail++; $display("FAIL fetch_m_we got=%b exp=0", arb_bus.m_we); end
    n_checks++; if (arb_bus.m_be !== 4'hF)         begin n_fail++; $display("FAIL fetch_m_be got=%h exp=f", arb_bus.m_be); end
    n_checks++; if (arb_bus.m_wdata !== 32'h0)     begin n_fail++; $display("FAIL fetch_m_wdata got=%h exp=0", arb_bus.m_wdata); end
    next_cycle();
    arb_bus.i_req    = 1'b0;
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'h0000_0013;
    @(negedge clk);
    n_checks++; if (arb_bus.i_rvalid !== 1'b1)     begin n_fail++; $display("FAIL fetch_i_rvalid got=%b exp=1", arb_bus.i_rvalid); end
    n_checks++; if (arb_bus.i_rdata !== 32'h13)    begin n_fail++; $display("FAIL fetch_i_rdata got=%h exp=13", arb_bus.i_rdata); end
    n_checks++; if (arb_bus.d_rvalid !== 1'b0)     begin n_fail++; $display("FAIL fetch_d_rvalid got=%b exp=0", arb_bus.d_rvalid); end
    n_checks++; if (arb_bus.m_req !== 1'b0)        begin n_fail++; $display("FAIL fetch_idle_m_req got=%b exp=0", arb_bus.m_req); end
    n_checks++; if ({arb_bus.m_we, arb_bus.m_be, arb_bus.m_addr, arb_bus.m_wdata} !== '0)
      begin n_fail++; $display("FAIL fetch_idle_m_fields got=%b/%h/%h/%h exp=0", arb_bus.m_we, arb_bus.m_be, arb_bus.m_addr, arb_bus.m_wdata); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_priority();
    arb_bus.i_req  = 1'b1;
    arb_bus.i_addr = 16'h0020;
    arb_bus.d_req  = 1'b1;
    arb_bus.d_addr = 16'h0080;
    arb_bus.d_be   = 4'hF;
    @(negedge clk);
    n_checks++; if (arb_bus.d_gnt !== 1'b1)      begin n_fail++; $display("FAIL prio_d_gnt got=%b exp=1", arb_bus.d_gnt); end
    n_checks++; if (arb_bus.i_gnt !== 1'b0)      begin n_fail++; $display("FAIL prio_i_gnt got=%b exp=0", arb_bus.i_gnt); end
    n_checks++; if (arb_bus.m_addr !== 16'h0080) begin n_fail++; $display("FAIL prio_m_addr got=%h exp=0080", arb_bus.m_addr); end
    next_cycle();
    arb_bus.d_req    = 1'b0;
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'hAAAA_0001;
    @(negedge clk);
    n_checks++; if (arb_bus.d_rvalid !== 1'b1)          begin n_fail++; $display("FAIL prio_d_rvalid got=%b exp=1", arb_bus.d_rvalid); end
    n_checks++; if (arb_bus.d_rdata !== 32'hAAAA_0001)  begin n_fail++; $display("FAIL prio_d_rdata got=%h exp=aaaa0001", arb_bus.d_rdata); end
    n_checks++; if (arb_bus.i_gnt !== 1'b1)             begin n_fail++; $display("FAIL prio_i_gnt2 got=%b exp=1", arb_bus.i_gnt); end
    n_checks++; if (arb_bus.m_addr !== 16'h0020)        begin n_fail++; $display("FAIL prio_m_addr2 got=%h exp=0020", arb_bus.m_addr); end
    n_checks++; if (arb_bus.i_rvalid !== 1'b0)          begin n_fail++; $display("FAIL prio_i_rvalid_early got=%b exp=0", arb_bus.i_rvalid); end
    next_cycle();
    arb_bus.i_req    = 1'b0;
    arb_bus.m_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (arb_bus.i_rvalid !== 1'b0 || arb_bus.m_req !== 1'b0)
      begin n_fail++; $display("FAIL prio_wait got rvalid=%b m_req=%b exp=0/0", arb_bus.i_rvalid, arb_bus.m_req); end
    next_cycle();
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'hBBBB_0002;
    @(negedge clk);
    n_checks++; if (arb_bus.i_rvalid !== 1'b1)          begin n_fail++; $display("FAIL prio_i_rvalid got=%b exp=1", arb_bus.i_rvalid); end
    n_checks++; if (arb_bus.i_rdata !== 32'hBBBB_0002)  begin n_fail++; $display("FAIL prio_i_rdata got=%h exp=bbbb0002", arb_bus.i_rdata); end
    n_checks++; if (arb_bus.d_rvalid !== 1'b0)          begin n_fail++; $display("FAIL prio_d_rvalid2 got=%b exp=0", arb_bus.d_rvalid); end
    next_cycle();
    drive_idle();
  endtask

  // Both requesters stay busy while memory answers every cycle
  task automatic test_starvation();
    for (int k = 0; k <= 10; k++) begin
      arb_bus.i_req    = (k < 10);
      arb_bus.i_addr   = 16'h0040;
      arb_bus.d_req    = (k < 10);
      arb_bus.d_we     = 1'b0;
      arb_bus.d_addr   = 16'(16'h0200 + k);
      arb_bus.m_rvalid = (k > 0);
      arb_bus.m_rdata  = 32'(k);
      @(negedge clk);
      if (k < 10) begin
        n_checks++; if (arb_bus.i_gnt !== (k == 4 || k == 9))
          begin n_fail++; $display("FAIL starve_i_gnt[%0d] got=%b exp=%b", k, arb_bus.i_gnt, (k == 4 || k == 9)); end
        n_checks++; if (arb_bus.d_gnt !== !(k == 4 || k == 9))
          begin n_fail++; $display("FAIL starve_d_gnt[%0d] got=%b exp=%b", k, arb_bus.d_gnt, !(k == 4 || k == 9)); end
      end
      if (k > 0) begin
        n_checks++; if (arb_bus.i_rvalid !== (k == 5 || k == 10))
          begin n_fail++; $display("FAIL starve_i_rvalid[%0d] got=%b exp=%b", k, arb_bus.i_rvalid, (k == 5 || k == 10)); end
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_write();
    arb_bus.d_req   = 1'b1;
    arb_bus.d_we    = 1'b1;
    arb_bus.d_be    = 4'b0011;
    arb_bus.d_addr  = 16'h0100;
    arb_bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (arb_bus.d_gnt !== 1'b1)            begin n_fail++; $display("FAIL wr_d_gnt got=%b exp=1", arb_bus.d_gnt); end
    n_checks++; if (arb_bus.m_we !== 1'b1)             begin n_fail++; $display("FAIL wr_m_we got=%b exp=1", arb_bus.m_we); end
    n_checks++; if (arb_bus.m_be !== 4'b0011)          begin n_fail++; $display("FAIL wr_m_be got=%b exp=0011", arb_bus.m_be); end
    n_checks++; if (arb_bus.m_addr !== 16'h0100)       begin n_fail++; $display("FAIL wr_m_addr got=%h exp=0100", arb_bus.m_addr); end
    n_checks++; if (arb_bus.m_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_m_wdata got=%h exp=deadbeef", arb_bus.m_wdata); end
    next_cycle();
    drive_idle();
    arb_bus.m_rvalid = 1'b1;
    @(negedge clk);
    n_checks++; if (arb_bus.d_rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_d_rvalid got=%b exp=1", arb_bus.d_rvalid); end
    n_checks++; if (arb_bus.i_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_i_rvalid got=%b exp=0", arb_bus.i_rvalid); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    arb_bus.d_req  = 1'b1;
    arb_bus.d_addr = 16'h0300;
    @(negedge clk);
    n_checks++; if (arb_bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_d_gnt got=%b exp=1", arb_bus.d_gnt); end
    next_cycle();
    arb_bus.d_req = 1'b0;
    #2;
    rst_n = 1'b0;
    arb_bus.m_rvalid = 1'b1;
    #1;
    n_checks++; if (arb_bus.d_rvalid !== 1'b0 || arb_bus.m_req !== 1'b0)
      begin n_fail++; $display("FAIL rmid_in_reset got d_rvalid=%b m_req=%b exp=0/0", arb_bus.d_rvalid, arb_bus.m_req); end
    arb_bus.m_rvalid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'h0000_0BAD;
    @(negedge clk);
    n_checks++; if (arb_bus.d_rvalid !== 1'b0 || arb_bus.i_rvalid !== 1'b0)
      begin n_fail++; $display("FAIL rmid_late_rvalid got d=%b i=%b exp=0/0", arb_bus.d_rvalid, arb_bus.i_rvalid); end
    next_cycle();
    arb_bus.m_rvalid = 1'b0;
    arb_bus.i_req    = 1'b1;
    arb_bus.i_addr   = 16'h0044;
    @(negedge clk);
    n_checks++; if (arb_bus.i_gnt !== 1'b1) begin n_fail++; $display("FAIL rmid_next_i_gnt got=%b exp=1", arb_bus.i_gnt); end
    next_cycle();
    arb_bus.i_req    = 1'b0;
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'h0000_0055;
    @(negedge clk);
    n_checks++; if (arb_bus.i_rvalid !== 1'b1 || arb_bus.i_rdata !== 32'h55)
      begin n_fail++; $display("FAIL rmid_next_resp got rvalid=%b rdata=%h exp=1/55", arb_bus.i_rvalid, arb_bus.i_rdata); end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_spurious();
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'h1234_5678;
    @(negedge clk);
    n_checks++; if (arb_bus.i_rvalid !== 1'b0 || arb_bus.d_rvalid !== 1'b0)
      begin n_fail++; $display("FAIL spur_rvalid got i=%b d=%b exp=0/0", arb_bus.i_rvalid, arb_bus.d_rvalid); end
    n_checks++; if (arb_bus.i_gnt !== 1'b0 || arb_bus.d_gnt !== 1'b0 || arb_bus.m_req !== 1'b0)
      begin n_fail++; $display("FAIL spur_gnt got i=%b d=%b m=%b exp=0/0/0", arb_bus.i_gnt, arb_bus.d_gnt, arb_bus.m_req); end
    next_cycle();
    arb_bus.m_rvalid = 1'b0;
    arb_bus.d_req    = 1'b1;
    arb_bus.d_addr   = 16'h0500;
    @(negedge clk);
    n_checks++; if (arb_bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL spur_after_d_gnt got=%b exp=1", arb_bus.d_gnt); end
    next_cycle();
    arb_bus.d_req    = 1'b0;
    arb_bus.m_rvalid = 1'b1;
    arb_bus.m_rdata  = 32'h0000_0077;
    @(negedge clk);
    n_checks++; if (arb_bus.d_rvalid !== 1'b1 || arb_bus.d_rdata !== 32'h77)
      begin n_fail++; $display("FAIL spur_after_resp got rvalid=%b rdata=%h exp=1/77", arb_bus.d_rvalid, arb_bus.d_rdata); end
    next_cycle();
    drive_idle();
  endtask

  // Transaction-level model: one outstanding job, a starvation tally,
  // a memory answering after 1..3 cycles and occasional stray responses
  task automatic test_random(input int n_cycles);
    bit        busy = 1'b0;
    bit        own_d = 1'b0;
    int        starve = 0;
    bit        mem_busy = 1'b0;
    int        mem_lat = 0;
    bit        drop_i = 1'b0;
    bit        drop_d = 1'b0;
    bit        e_gi, e_gd, e_ri, e_rd, e_we;
    logic [3:0]  e_be;
    logic [15:0] e_addr;
    logic [31:0] e_wdata;
    for (int c = 0; c < n_cycles; c++) begin
      if (drop_i || !arb_bus.i_req) begin
        arb_bus.i_req  = ($urandom_range(0, 3) != 0);
        arb_bus.i_addr = 16'($urandom);
      end
      if (drop_d || !arb_bus.d_req) begin
        arb_bus.d_req   = ($urandom_range(0, 9) < 7);
        arb_bus.d_we    = 1'($urandom);
        arb_bus.d_be    = 4'($urandom);
        arb_bus.d_addr  = 16'($urandom);
        arb_bus.d_wdata = $urandom;
      end
      arb_bus.m_rdata = $urandom;
      if (mem_busy) begin
        arb_bus.m_rvalid = (mem_lat == 0);
        if (mem_lat > 0) mem_lat--;
      end else begin
        arb_bus.m_rvalid = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);

      e_ri = busy && arb_bus.m_rvalid && !own_d;
      e_rd = busy && arb_bus.m_rvalid && own_d;
      e_gd = 1'b0;
      e_gi = 1'b0;
      if (!busy || arb_bus.m_rvalid) begin
        if (arb_bus.i_req && starve >= LIMIT) e_gi = 1'b1;
        else if (arb_bus.d_req)               e_gd = 1'b1;
        else if (arb_bus.i_req)               e_gi = 1'b1;
      end
      e_we = 1'b0; e_be = 4'h0; e_addr = 16'h0; e_wdata = 32'h0;
      if (e_gd) begin
        e_we = arb_bus.d_we; e_be = arb_bus.d_be; e_addr = arb_bus.d_addr; e_wdata = arb_bus.d_wdata;
      end else if (e_gi) begin
        e_be = 4'hF; e_addr = arb_bus.i_addr;
      end

      n_checks++; if (arb_bus.i_gnt !== e_gi || arb_bus.d_gnt !== e_gd || arb_bus.m_req !== (e_gi || e_gd))
        begin n_fail++; $display("FAIL rnd_gnt c=%0d got i=%b d=%b m=%b exp i=%b d=%b m=%b", c, arb_bus.i_gnt, arb_bus.d_gnt, arb_bus.m_req, e_gi, e_gd, e_gi || e_gd); end
      n_checks++; if ({arb_bus.m_we, arb_bus.m_be, arb_bus.m_addr, arb_bus.m_wdata} !== {e_we, e_be, e_addr, e_wdata})
        begin n_fail++; $display("FAIL rnd_mcmd c=%0d got %b/%h/%h/%h exp %b/%h/%h/%h", c, arb_bus.m_we, arb_bus.m_be, arb_bus.m_addr, arb_bus.m_wdata, e_we, e_be, e_addr, e_wdata); end
      n_checks++; if (arb_bus.i_rvalid !== e_ri || arb_bus.d_rvalid !== e_rd)
        begin n_fail++; $display("FAIL rnd_rvalid c=%0d got i=%b d=%b exp i=%b d=%b", c, arb_bus.i_rvalid, arb_bus.d_rvalid, e_ri, e_rd); end
      if (e_ri) begin
        n_checks++; if (arb_bus.i_rdata !== arb_bus.m_rdata) begin n_fail++; $display("FAIL rnd_i_rdata c=%0d got=%h exp=%h", c, arb_bus.i_rdata, arb_bus.m_rdata); end
      end
      if (e_rd) begin
        n_checks++; if (arb_bus.d_rdata !== arb_bus.m_rdata) begin n_fail++; $display("FAIL rnd_d_rdata c=%0d got=%h exp=%h", c, arb_bus.d_rdata, arb_bus.m_rdata); end
      end

      if (e_gd) starve = arb_bus.i_req ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
      if (e_gi) starve = 0;
      if (e_gi || e_gd) begin
        busy  = 1'b1;
        own_d = e_gd;
      end else if (busy && arb_bus.m_rvalid) begin
        busy = 1'b0;
      end
      if (mem_busy && arb_bus.m_rvalid) mem_busy = 1'b0;
      if (e_gi || e_gd) begin
        mem_busy = 1'b1;
        mem_lat  = $urandom_range(0, 2);
      end
      drop_i = e_gi;
      drop_d = e_gd;
      next_cycle();
    end
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      arb_bus.m_rvalid = (k == 0) && mem_busy;
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_write();
    test_reset_mid();
    test_spurious();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, byte address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, word width of all data buses.
REQ-003 Parameter STARVE_LIMIT, default 4, max consecutive data grants while instruction request pending.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 i_req  in  1  instruction fetch request; i_addr  in  ADDRESS_WIDTH  fetch byte address.
REQ-007 i_gnt  out  1  fetch accepted this cycle; i_rvalid  out  1  fetch data valid; i_rdata  out  DATA_WIDTH  fetch word.
REQ-008 d_req  in  1  data request; d_we  in  1  write when 1; d_be  in  DATA_WIDTH/8  byte enables; d_addr  in  ADDRESS_WIDTH; d_wdata  in  DATA_WIDTH.
REQ-009 d_gnt  out  1  data accepted; d_rvalid  out  1  read data or write ack valid; d_rdata  out  DATA_WIDTH.
REQ-010 m_req, m_we  out  1; m_be  out  DATA_WIDTH/8; m_addr  out  ADDRESS_WIDTH; m_wdata  out  DATA_WIDTH: shared memory command.
REQ-011 m_rvalid  in  1  memory response (read data or write ack); m_rdata  in  DATA_WIDTH.

Function
REQ-012 States IDLE (no outstanding) and WAIT (one outstanding); at most one memory transaction outstanding.
REQ-013 Grant is combinational: in IDLE, or in WAIT during the m_rvalid cycle, a pending request is granted same cycle, m_req=1 with winner's fields; state is WAIT next cycle.
REQ-014 In WAIT without m_rvalid: i_gnt=d_gnt=m_req=0; requesters hold req and fields until gnt.
REQ-015 Priority: data beats instruction unless starvation counter equals STARVE_LIMIT and i_req=1, then instruction wins.
REQ-016 Starvation counter (width clog2(STARVE_LIMIT+1)): +1 on data grant with i_req=1; cleared on any instruction grant or on data grant with i_req=0; saturates at STARVE_LIMIT.
REQ-017 Owner register records winner at grant; on m_rvalid in WAIT, owner's rvalid=1 and rdata=m_rdata same cycle; other rvalid=0.
REQ-018 Instruction grants drive m_we=0, m_be all ones, m_wdata=0.
REQ-019 On m_rvalid in WAIT with no new grant, state returns to IDLE.
REQ-020 m_rvalid in IDLE is ignored: no rvalid out, no state change.
REQ-021 Addresses forwarded unmodified; alignment is the requester's responsibility.
REQ-022 When m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0.

Reset
REQ-023 rst_n low: state IDLE, owner instruction, counter 0, all gnt/rvalid/m_req outputs 0, immediately, without clk.
REQ-024 Reset mid-transaction discards the outstanding response; late m_rvalid after reset falls under REQ-020.
REQ-025 First grant possible in the first cycle with rst_n high.

Structure
REQ-026 Package mem_arb_pkg holds state enum (IDLE, WAIT) and owner enum (OWN_I, OWN_D).
REQ-027 Starvation counter is sub-module arb_starve_ctr (inputs inc, clr; output at_limit); remainder flat.
REQ-028 Target size 120-400 lines RTL including sub-module.

Verification
REQ-029 Single fetch: i_req, i_addr=0x0010, m_rdata=0x00000013 next cycle -> i_gnt cycle 0, i_rvalid=1 and i_rdata=0x00000013 cycle 1.
REQ-030 Simultaneous i_req, d_req read at IDLE -> d_gnt first; i_gnt in d_rvalid cycle; both rdata routed correctly.
REQ-031 d_req held high continuously with i_req high, STARVE_LIMIT=4 -> exactly 4 data grants, then i_gnt, then counter 0.
REQ-032 Data write d_be=0011, d_wdata=0xDEADBEEF, d_addr=0x0100 -> m_we=1, m_be=0011, m_addr=0x0100; d_rvalid on ack, i_rvalid stays 0.
REQ-033 rst_n low during WAIT, m_rvalid one cycle after release -> no rvalid, state IDLE, next request granted normally.
REQ-034 Spurious m_rvalid in IDLE with no requests -> i_rvalid=d_rvalid=0, no grants.
